// File: rtl/dac_pb_pkg.sv
// rtl/dac_pb_pkg.sv - shared types and constants for the DAC playback engine
package dac_pb_pkg;

    typedef enum logic [1:0] {
        PB_ONESHOT  = 2'd0,
        PB_LOOP     = 2'd1,
        PB_PINGPONG = 2'd2
    } pb_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pb_state_e;

    // Mid-scale code driven by an idle channel
    localparam logic [13:0] PB_IDLE_CODE = 14'h2000;

endpackage

// File: rtl/dac_pb_channel.sv
// rtl/dac_pb_channel.sv - one playback channel: FSM, rate divider, address walker, DAC register
module dac_pb_channel
    import dac_pb_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 11,
    parameter int                   DAC_WIDTH  = 14,
    parameter int                   DIV_WIDTH  = 16,
    parameter logic [DAC_WIDTH-1:0] IDLE_CODE  = PB_IDLE_CODE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [15:0]           mem_data_i,
    output logic [DAC_WIDTH-1:0]  dac_o,
    output logic                  done_o,
    output logic                  run_nxt_o
);

    pb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, nxt_addr, last_addr;
    logic                  dir_q, dir_d, nxt_dir;
    logic [DIV_WIDTH-1:0]  tick_q, tick_d, div_q, div_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [1:0]            mode_q, mode_d;
    logic                  rd_q, rd_d, done_q, done_d;
    logic                  rd_dly_q;
    logic [DAC_WIDTH-1:0]  dac_q;
    logic                  unused_hi;

    assign unused_hi = ^mem_data_i[15:DAC_WIDTH];

    // Low bits of len minus one; len = 2^ADDR_WIDTH gives the all-ones address
    assign last_addr = len_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    // Address and direction that follow the current one for the latched mode
    always_comb begin
        nxt_addr = addr_q + ADDR_WIDTH'(1);
        nxt_dir  = dir_q;
        if (mode_q == PB_LOOP) begin
            if (addr_q == last_addr) nxt_addr = '0;
        end else if (mode_q == PB_PINGPONG) begin
            if (len_q == (ADDR_WIDTH+1)'(1)) begin
                nxt_addr = '0;
            end else if (!dir_q) begin
                if (addr_q == last_addr) begin
                    nxt_dir  = 1'b1;
                    nxt_addr = addr_q - ADDR_WIDTH'(1);
                end
            end else if (addr_q == '0) begin
                nxt_dir = 1'b0;
            end else begin
                nxt_addr = addr_q - ADDR_WIDTH'(1);
            end
        end
    end

    // Channel FSM with read scheduling; mode 3 falls through as one-shot
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        tick_d  = tick_q;
        rd_d    = 1'b0;
        done_d  = done_q;
        len_d   = len_q;
        mode_d  = mode_q;
        div_d   = div_q;
        if (!en_i) begin
            state_d = IDLE;
            addr_d  = '0;
            dir_d   = 1'b0;
            tick_d  = '0;
            done_d  = 1'b0;
        end else if (start_i) begin
            len_d  = len_i;
            mode_d = mode_i;
            div_d  = div_i;
            addr_d = '0;
            dir_d  = 1'b0;
            tick_d = div_i;
            if (len_i == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                done_d  = 1'b0;
                rd_d    = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (rd_q && mode_q != PB_LOOP && mode_q != PB_PINGPONG && addr_q == last_addr) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else if (tick_q == '0) begin
                tick_d = div_q;
                rd_d   = 1'b1;
                addr_d = nxt_addr;
                dir_d  = nxt_dir;
            end else begin
                tick_d = tick_q - DIV_WIDTH'(1);
            end
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            tick_q  <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            mode_q  <= PB_ONESHOT;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
        end
    end

    // Track the cycle read data returns and hold the last code between reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_dly_q <= 1'b0;
            dac_q    <= IDLE_CODE;
        end else if (!en_i) begin
            rd_dly_q <= 1'b0;
            dac_q    <= IDLE_CODE;
        end else begin
            rd_dly_q <= rd_q;
            if (rd_dly_q) dac_q <= mem_data_i[DAC_WIDTH-1:0];
        end
    end

    // Returning data reaches the DAC in the cycle it is valid
    assign dac_o      = rd_dly_q ? mem_data_i[DAC_WIDTH-1:0] : dac_q;
    assign mem_addr_o = addr_q;
    assign mem_rd_o   = rd_q;
    assign done_o     = done_q;
    assign run_nxt_o  = (state_d == RUN);

endmodule

// File: rtl/dac_playback_ctrl.sv
// rtl/dac_playback_ctrl.sv - multi-channel DAC waveform playback engine
module dac_playback_ctrl
    import dac_pb_pkg::*;
#(
    parameter int                   NUM_CH     = 2,
    parameter int                   ADDR_WIDTH = 11,
    parameter int                   DAC_WIDTH  = 14,
    parameter int                   DIV_WIDTH  = 16,
    parameter logic [DAC_WIDTH-1:0] IDLE_CODE  = PB_IDLE_CODE
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           start_i,
    input  logic [NUM_CH-1:0]              en_i,
    input  logic [2*NUM_CH-1:0]            mode_i,
    input  logic [(ADDR_WIDTH+1)*NUM_CH-1:0] len_i,
    input  logic [DIV_WIDTH*NUM_CH-1:0]    div_i,
    output logic [ADDR_WIDTH*NUM_CH-1:0]   mem_addr_o,
    output logic [NUM_CH-1:0]              mem_rd_o,
    input  logic [16*NUM_CH-1:0]           mem_data_i,
    output logic [DAC_WIDTH*NUM_CH-1:0]    dac_o,
    output logic [NUM_CH-1:0]              done_o,
    output logic                           busy_o
);

    logic [NUM_CH-1:0] run_nxt;
    logic              busy_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dac_pb_channel #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DAC_WIDTH  (DAC_WIDTH),
            .DIV_WIDTH  (DIV_WIDTH),
            .IDLE_CODE  (IDLE_CODE)
        ) u_ch (
            .clk_i      (sys_clk),
            .rst_ni     (sys_rst_n),
            .start_i    (start_i),
            .en_i       (en_i[i]),
            .mode_i     (mode_i[2*i +: 2]),
            .len_i      (len_i[(ADDR_WIDTH+1)*i +: ADDR_WIDTH+1]),
            .div_i      (div_i[DIV_WIDTH*i +: DIV_WIDTH]),
            .mem_addr_o (mem_addr_o[ADDR_WIDTH*i +: ADDR_WIDTH]),
            .mem_rd_o   (mem_rd_o[i]),
            .mem_data_i (mem_data_i[16*i +: 16]),
            .dac_o      (dac_o[DAC_WIDTH*i +: DAC_WIDTH]),
            .done_o     (done_o[i]),
            .run_nxt_o  (run_nxt[i])
        );
    end

    // Busy is registered alongside the channel states it summarises
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) busy_q <= 1'b0;
        else            busy_q <= |run_nxt;
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// tb/tb_dac_playback_ctrl.sv - self-checking bench for dac_playback_ctrl
module tb_dac_playback_ctrl;

    localparam int NCH = 4;
    localparam int AW  = 11;
    localparam int DW  = 14;
    localparam int VW  = 16;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic [NCH-1:0]        en_i = '0;
    logic [2*NCH-1:0]      mode_i = '0;
    logic [(AW+1)*NCH-1:0] len_i = '0;
    logic [VW*NCH-1:0]     div_i = '0;
    logic [AW*NCH-1:0]     mem_addr_o;
    logic [NCH-1:0]        mem_rd_o;
    logic [16*NCH-1:0]     mem_data_i = '0;
    logic [DW*NCH-1:0]     dac_o;
    logic [NCH-1:0]        done_o;
    logic                  busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dac_playback_ctrl #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .DAC_WIDTH(DW), .DIV_WIDTH(VW), .IDLE_CODE(14'h2000)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_i(start_i), .en_i(en_i),
        .mode_i(mode_i), .len_i(len_i), .div_i(div_i), .mem_addr_o(mem_addr_o),
        .mem_rd_o(mem_rd_o), .mem_data_i(mem_data_i), .dac_o(dac_o), .done_o(done_o),
        .busy_o(busy_o)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [13:0] exp_code(int c, int a);
        return 14'(c * 2048 + a + 100);
    endfunction

    // Sample RAM: registered read port, upper two bits deliberately non-zero
    always @(posedge sys_clk)
        for (int c = 0; c < NCH; c++)
            if (mem_rd_o[c])
                mem_data_i[c*16 +: 16] <= {2'b11, exp_code(c, int'(mem_addr_o[c*AW +: AW]))};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int addr_of(int c);
        return int'(mem_addr_o[c*AW +: AW]);
    endfunction

    function automatic logic [13:0] dac_of(int c);
        return dac_o[c*DW +: DW];
    endfunction

    task automatic set_ch(int c, int mode, int len, int dv);
        mode_i[c*2 +: 2]       = 2'(mode);
        len_i[c*(AW+1) +: AW+1] = 12'(len);
        div_i[c*VW +: VW]      = 16'(dv);
    endtask

    task automatic idle_all();
        @(posedge sys_clk); #1;
        en_i = '0;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        @(posedge sys_clk); #1;
        start_i = 1'b1;
        t = cyc;
        @(posedge sys_clk); #1;
        start_i = 1'b0;
    endtask

    typedef struct {
        int ch;
        int mode;
        int len;
        int dv;
        int nrd;
        bit exp_done;
        int exp_addr[12];
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    function automatic vec_t mk(int ch, int mode, int len, int dv, int nrd, bit dn);
        vec_t v;
        v.ch = ch; v.mode = mode; v.len = len; v.dv = dv; v.nrd = nrd; v.exp_done = dn;
        for (int i = 0; i < 12; i++) v.exp_addr[i] = 0;
        return v;
    endfunction

    initial begin
        int t;
        int n;
        int per;
        int ch;
        int got_a[16];
        int got_o[16];
        bit found;

        vecs[0] = mk(0, 0, 4, 0, 4, 1'b1);
        vecs[0].exp_addr = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = mk(1, 1, 3, 2, 6, 1'b0);
        vecs[1].exp_addr = '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0};
        vecs[2] = mk(2, 2, 4, 0, 9, 1'b0);
        vecs[2].exp_addr = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 0, 0, 0};
        vecs[3] = mk(3, 2, 1, 0, 4, 1'b0);
        vecs[3].exp_addr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = mk(0, 2, 2, 1, 5, 1'b0);
        vecs[4].exp_addr = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5] = mk(2, 3, 2, 0, 2, 1'b1);
        vecs[5].exp_addr = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rst_dac%0d", c), 32'(dac_of(c)), 32'h2000);
            chk($sformatf("rst_addr%0d", c), 32'(addr_of(c)), 0);
        end
        chk("rst_rd", 32'(mem_rd_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_busy", 32'(busy_o), 0);

        // Table-driven address sequences and read spacing
        for (int v = 0; v < NV; v++) begin
            ch  = vecs[v].ch;
            per = vecs[v].dv + 1;
            idle_all();
            set_ch(ch, vecs[v].mode, vecs[v].len, vecs[v].dv);
            en_i = '0;
            en_i[ch] = 1'b1;
            pulse_start(t);
            n = 0;
            for (int k = 0; k < vecs[v].nrd * per; k++) begin
                @(negedge sys_clk);
                if (mem_rd_o[ch]) begin
                    if (n < 16) begin
                        got_a[n] = addr_of(ch);
                        got_o[n] = cyc - t;
                    end
                    n++;
                end
            end
            chk($sformatf("v%0d_nreads", v), n, vecs[v].nrd);
            for (int i = 0; i < vecs[v].nrd && i < n && i < 16; i++) begin
                chk($sformatf("v%0d_addr%0d", v, i), got_a[i], vecs[v].exp_addr[i]);
                chk($sformatf("v%0d_cyc%0d", v, i), got_o[i], 1 + i * per);
            end
            @(negedge sys_clk);
            chk($sformatf("v%0d_done", v), 32'(done_o[ch]), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_busy", v), 32'(busy_o), 32'(!vecs[v].exp_done));
            chk($sformatf("v%0d_dac", v), 32'(dac_of(ch)),
                32'(exp_code(ch, vecs[v].exp_addr[vecs[v].nrd-1])));
        end

        // One-shot cycle-exact DAC and done timing
        idle_all();
        set_ch(0, 0, 4, 0);
        en_i = 4'b0001;
        pulse_start(t);
        for (int off = 1; off <= 7; off++) begin
            @(negedge sys_clk);
            chk($sformatf("os_rd_t%0d", off), 32'(mem_rd_o[0]), 32'(off <= 4));
            chk($sformatf("os_done_t%0d", off), 32'(done_o[0]), 32'(off >= 5));
            if (off >= 2 && off <= 5)
                chk($sformatf("os_dac_t%0d", off), 32'(dac_of(0)), 32'(exp_code(0, off - 2)));
            if (off >= 6)
                chk($sformatf("os_hold_t%0d", off), 32'(dac_of(0)), 32'(exp_code(0, 3)));
        end

        // Zero length: straight to done, never reads
        idle_all();
        set_ch(1, 0, 0, 0);
        en_i = 4'b0010;
        pulse_start(t);
        for (int off = 1; off <= 3; off++) begin
            @(negedge sys_clk);
            chk($sformatf("len0_rd_t%0d", off), 32'(mem_rd_o[1]), 0);
            chk($sformatf("len0_done_t%0d", off), 32'(done_o[1]), 1);
            chk($sformatf("len0_busy_t%0d", off), 32'(busy_o), 0);
        end

        // Enable dropped mid-run
        idle_all();
        set_ch(0, 1, 8, 0);
        en_i = 4'b0001;
        pulse_start(t);
        repeat (3) @(negedge sys_clk);
        chk("abort_busy_before", 32'(busy_o), 1);
        en_i = 4'b0000;
        @(negedge sys_clk);
        chk("abort_dac", 32'(dac_of(0)), 32'h2000);
        chk("abort_rd", 32'(mem_rd_o[0]), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o[0]), 0);

        // Restart while running at address 5
        idle_all();
        set_ch(0, 1, 8, 0);
        en_i = 4'b0001;
        pulse_start(t);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge sys_clk);
            if (mem_rd_o[0] && addr_of(0) == 5) found = 1'b1;
        end
        chk("restart_reach5", 32'(found), 1);
        start_i = 1'b1;
        @(posedge sys_clk); #1;
        start_i = 1'b0;
        @(negedge sys_clk);
        chk("restart_rd", 32'(mem_rd_o[0]), 1);
        chk("restart_addr", 32'(addr_of(0)), 0);

        // Restart from DONE clears the flag
        set_ch(0, 0, 3, 0);
        pulse_start(t);
        repeat (5) @(negedge sys_clk);
        chk("redone_done_set", 32'(done_o[0]), 1);
        start_i = 1'b1;
        @(posedge sys_clk); #1;
        start_i = 1'b0;
        @(negedge sys_clk);
        chk("redone_done_clr", 32'(done_o[0]), 0);
        chk("redone_rd", 32'(mem_rd_o[0]), 1);
        chk("redone_addr", 32'(addr_of(0)), 0);

        // Full-depth loop wraps 2047 -> 0
        idle_all();
        set_ch(3, 1, 2048, 0);
        en_i = 4'b1000;
        pulse_start(t);
        repeat (2047) @(negedge sys_clk);
        @(negedge sys_clk);
        chk("full_rd_2047", 32'(mem_rd_o[3]), 1);
        chk("full_addr_2047", 32'(addr_of(3)), 2047);
        @(negedge sys_clk);
        chk("full_rd_wrap", 32'(mem_rd_o[3]), 1);
        chk("full_addr_wrap", 32'(addr_of(3)), 0);
        chk("full_dac_2047", 32'(dac_of(3)), 32'(exp_code(3, 2047)));

        // All channels launched together stay read-aligned
        idle_all();
        set_ch(0, 0, 5, 1);
        set_ch(1, 1, 5, 1);
        set_ch(2, 2, 5, 1);
        set_ch(3, 1, 3, 1);
        en_i = 4'b1111;
        pulse_start(t);
        for (int off = 1; off <= 6; off++) begin
            @(negedge sys_clk);
            chk($sformatf("align_rd_t%0d", off), 32'(mem_rd_o), (off % 2 == 1) ? 32'hF : 32'h0);
        end
        chk("align_busy", 32'(busy_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_playback_ctrl.md
Name: dac_playback_ctrl

Overview:
Multi-channel waveform playback engine for the DAC path, generalising the two-channel DAC memory controller. Each of NUM_CH channels reads samples from its own dual-port sample RAM read port and drives a DAC code. Per-channel controls: enable, length, rate divider and mode (one-shot, loop, ping-pong). A common start pulse launches all enabled channels phase-aligned. Controls come from CSR fields; outputs feed the dac pin driver.

Parameters:
NUM_CH, 2, number of playback channels
ADDR_WIDTH, 11, sample RAM address width per channel
DAC_WIDTH, 14, DAC code width, taken from mem_data_i[DAC_WIDTH-1:0] of each 16-bit word
DIV_WIDTH, 16, rate divider width
IDLE_CODE, 14'h2000, output code when a channel is idle (mid-scale)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse that launches all enabled channels
en_i  in  NUM_CH  per-channel enable (level)
mode_i  in  2*NUM_CH  per-channel mode: 0 one-shot, 1 loop, 2 ping-pong, 3 reserved (treated as one-shot)
len_i  in  (ADDR_WIDTH+1)*NUM_CH  per-channel sample count, range 0..2^ADDR_WIDTH
div_i  in  DIV_WIDTH*NUM_CH  per-channel sample period minus 1, in sys_clk cycles
mem_addr_o  out  ADDR_WIDTH*NUM_CH  per-channel RAM read address
mem_rd_o  out  NUM_CH  per-channel read strobe
mem_data_i  in  16*NUM_CH  per-channel RAM read data, valid 1 cycle after mem_rd_o
dac_o  out  DAC_WIDTH*NUM_CH  per-channel DAC code
done_o  out  NUM_CH  per-channel one-shot completion flag (sticky until next start)
busy_o  out  1  OR of all channels in RUN

Behaviour:
- Reset values: dac_o = IDLE_CODE on every channel; mem_addr_o = 0; mem_rd_o = 0; done_o = 0; busy_o = 0; all channels IDLE, direction up, tick counter 0.
- Per-channel FSM has three states: IDLE, RUN and DONE.
- IDLE -> RUN: on start_i with en_i=1 and len>0. len, mode and div are latched at this moment. Later changes take effect only on the next start.
- start_i with en_i=1 and len=0: go straight to DONE and set done_o the next cycle. No read is issued.
- start_i in RUN or DONE: restart from address 0 with direction up, clear done_o, and relatch the controls.
- en_i falling in RUN or DONE: go to IDLE the next cycle. dac_o returns to IDLE_CODE and done_o clears.
- Timing in RUN:
  - The first read issues in the cycle after start_i (T+1), at address 0.
  - After that a read issues every div+1 cycles. div=0 means one sample per cycle.
  - mem_rd_o is high for exactly one cycle per read.
  - dac_o updates in the cycle after the read (start at T gives the first new code at T+2) and holds between reads.
- Address sequence:
  - one-shot: 0..len-1. After the read of len-1, go to DONE, hold the last code and set done_o together with that final dac_o update.
  - loop: 0..len-1, then wrap to 0, indefinitely.
  - ping-pong: 0,1,..,len-1,len-2,..,1,0,1,... Endpoints are not repeated. len=1 reads address 0 repeatedly. len=2 alternates 0,1.
- Full-depth length: len = 2^ADDR_WIDTH is legal. The address counter wraps naturally, with no overflow into neighbouring bits.
- Simultaneous start_i and en_i falling: not applicable, since start_i only acts when en_i=1 in the same cycle.
- All channels started by the same start_i issue reads in the same cycles while their div values match.
- busy_o is the registered OR of the per-channel RUN states.
- Out-of-range data: bits [15:DAC_WIDTH] of mem_data_i are ignored.

Decomposition:
- Shared package dac_pb_pkg holds:
  - pb_mode_e enum (PB_ONESHOT=0, PB_LOOP=1, PB_PINGPONG=2)
  - pb_state_e enum (IDLE, RUN, DONE)
  - IDLE_CODE default constant
- Sub-module dac_pb_channel implements one channel: FSM, divider, address/direction counter and output register. The top instantiates it NUM_CH times with a generate loop and ORs busy.

Test Plan:
- One-shot: ch0 len=4, div=0, start at T -> mem_addr 0,1,2,3 with mem_rd at T+1..T+4. dac_o follows RAM contents T+2..T+5. done_o[0]=1 from T+5. dac_o then holds word 3.
- Loop plus divider: ch1 len=3, div=2 -> reads every 3rd cycle at addresses 0,1,2,0,1,2. busy_o stays 1 and done_o[1] stays 0.
- Ping-pong: len=4, div=0 -> address sequence 0,1,2,3,2,1,0,1,2. len=1 -> address 0 every cycle.
- Boundaries:
  - len=0 with start -> no mem_rd, and done_o=1 one cycle after start.
  - len=2048 loop -> address 2047 is followed by 0.
- Abort and restart:
  - en_i dropped mid-run -> next cycle dac_o=14'h2000, mem_rd=0, busy_o=0.
  - start_i during RUN at address 5 -> next read is at address 0 and done_o is cleared.
- Multi-channel alignment: NUM_CH=4, all div=1, single start -> mem_rd_o=4'hF in identical cycles. After reset, all dac_o read 14'h2000.
